id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the five-stage RV32I core, directly upstream of the forwarding unit and the EX operand muxes.
- Captures decoded fields, operand data and control from ID each cycle.
- Supplies ID_EX_rs1/ID_EX_rs2 and EX control to the forwarding unit and ALU.
- Contains load-use hazard detection, bubble insertion, flush handling and two saturating event counters.

Parameters:
XLEN, 32, datapath width (pc, register data, immediate)
CNT_W, 16, width of bubble_cnt and flush_cnt

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall_in  in  1  downstream hold request (MEM wait); freezes register
flush  in  1  branch/jump redirect from EX; kill instruction entering ID/EX
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  4  ALU operation
id_alu_src  in  1  1 = immediate operand B
id_mem_rd_en, id_mem_wr_en, id_mem_to_reg, id_reg_wr_en, id_branch, id_jump  in  1 each  control
ID_EX_valid, ID_EX_pc, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_alu_op, ID_EX_alu_src, ID_EX_mem_rd_en, ID_EX_mem_wr_en, ID_EX_mem_to_reg, ID_EX_reg_wr_en, ID_EX_branch, ID_EX_jump  out  widths as inputs  registered copies
load_use_stall  out  1  freeze PC and IF/ID this cycle
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
flush_cnt  out  CNT_W  flush events applied, saturating

Behaviour:
- Reset: when rst_n=0 at a clk edge, every ID_EX_* output clears to 0 (valid=0, rs1=rs2=rd=0, all enables 0) and both counters clear to 0.
- Bubble = all ID_EX_* fields 0. Because rs1=rs2=0, the forwarding unit never forwards into a bubble.
- Hazard (combinational): hz = ID_EX_valid & ID_EX_mem_rd_en & ID_EX_reg_wr_en & (ID_EX_rd != 0) & ((id_rs1_used & id_rs1 == ID_EX_rd) | (id_rs2_used & id_rs2 == ID_EX_rd)) & id_valid.
- load_use_stall = hz & ~flush. It has no registered delay and is asserted in the same cycle hz is detected.
- Next-state priority, evaluated at each rising edge:
  1. !rst_n: reset.
  2. flush: load bubble; flush_cnt += 1. Flush wins over stall_in and hazard.
  3. stall_in: hold all ID_EX_* unchanged; counters unchanged. Hazard is not counted while held.
  4. hz: load bubble; bubble_cnt += 1.
  5. else: capture all id_* inputs. id_valid=0 captures as a full bubble, not just valid=0.
- Exactly one bubble per load-use pair. In the following cycle the load is in EX/MEM, hz drops, and the dependent instruction is captured. MEM_WB forwarding covers it.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-stall or mid-hazard: reset wins; the next post-reset cycle behaves as rule 5 unless other inputs dictate.
- Latency: one cycle from ID inputs to ID_EX_* outputs. No combinational path from id_* data to ID_EX_* outputs.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with id_valid=1, id_rd=5 -> all ID_EX_* =0, bubble_cnt=flush_cnt=0. Release; next edge captures id_pc=0x100, ID_EX_rd=5.
- Load-use: lw x5 (ID_EX_mem_rd_en=1, rd=5) followed by add x6,x5,x1 in ID -> load_use_stall=1 that cycle. Next edge: ID_EX is a bubble (rs1=rs2=0), bubble_cnt=1. Next edge: add captured, ID_EX_rs1=5.
- No false hazard: lw x0 then use of x0, or lw x5 then instruction with id_rs1_used=0 and id_rs1=5 -> load_use_stall=0, no bubble.
- Flush priority: flush=1 together with stall_in=1 and an active hazard -> next edge bubble, flush_cnt=1, bubble_cnt unchanged, load_use_stall=0.
- Stall hold: stall_in=1 for 3 cycles with changing id_* inputs -> ID_EX_* constant (e.g. pc=0x200) throughout; on release, ID contents captured.
- Saturation: CNT_W=4, force 20 consecutive load-use bubbles -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID state, detects load-use hazards,
// inserts bubbles on hazard or flush, and counts both events with saturation.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_rd_en,
    input  logic             id_mem_wr_en,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_wr_en,
    input  logic             id_branch,
    input  logic             id_jump,
    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [XLEN-1:0]  ID_EX_rs1_data,
    output logic [XLEN-1:0]  ID_EX_rs2_data,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic [3:0]       ID_EX_alu_op,
    output logic             ID_EX_alu_src,
    output logic             ID_EX_mem_rd_en,
    output logic             ID_EX_mem_wr_en,
    output logic             ID_EX_mem_to_reg,
    output logic             ID_EX_reg_wr_en,
    output logic             ID_EX_branch,
    output logic             ID_EX_jump,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            mem_rd_en;
        logic            mem_wr_en;
        logic            mem_to_reg;
        logic            reg_wr_en;
        logic            branch;
        logic            jump;
    } ex_fields_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_fields_t       r_ex;
    ex_fields_t       w_id;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_hz;

    assign w_id = '{
        valid:      id_valid,
        pc:         id_pc,
        rs1:        id_rs1,
        rs2:        id_rs2,
        rd:         id_rd,
        rs1_data:   id_rs1_data,
        rs2_data:   id_rs2_data,
        imm:        id_imm,
        alu_op:     id_alu_op,
        alu_src:    id_alu_src,
        mem_rd_en:  id_mem_rd_en,
        mem_wr_en:  id_mem_wr_en,
        mem_to_reg: id_mem_to_reg,
        reg_wr_en:  id_reg_wr_en,
        branch:     id_branch,
        jump:       id_jump
    };

    // A load writing x0 never creates a dependency, so rd==0 is excluded.
    assign w_rs1_hit = id_rs1_used && (id_rs1 == r_ex.rd);
    assign w_rs2_hit = id_rs2_used && (id_rs2 == r_ex.rd);
    assign w_hz = r_ex.valid && r_ex.mem_rd_en && r_ex.reg_wr_en && (r_ex.rd != 5'd0)
                  && (w_rs1_hit || w_rs2_hit) && id_valid;

    assign load_use_stall = w_hz && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush) begin
            r_ex <= '0;
            if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (!stall_in) begin
            if (w_hz) begin
                r_ex <= '0;
                if (r_bubble_cnt != CNT_MAX) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end else if (id_valid) begin
                r_ex <= w_id;
            end else begin
                // An empty ID slot becomes a full bubble so no stale rs/rd reaches forwarding.
                r_ex <= '0;
            end
        end
    end

    assign ID_EX_valid      = r_ex.valid;
    assign ID_EX_pc         = r_ex.pc;
    assign ID_EX_rs1        = r_ex.rs1;
    assign ID_EX_rs2        = r_ex.rs2;
    assign ID_EX_rd         = r_ex.rd;
    assign ID_EX_rs1_data   = r_ex.rs1_data;
    assign ID_EX_rs2_data   = r_ex.rs2_data;
    assign ID_EX_imm        = r_ex.imm;
    assign ID_EX_alu_op     = r_ex.alu_op;
    assign ID_EX_alu_src    = r_ex.alu_src;
    assign ID_EX_mem_rd_en  = r_ex.mem_rd_en;
    assign ID_EX_mem_wr_en  = r_ex.mem_wr_en;
    assign ID_EX_mem_to_reg = r_ex.mem_to_reg;
    assign ID_EX_reg_wr_en  = r_ex.reg_wr_en;
    assign ID_EX_branch     = r_ex.branch;
    assign ID_EX_jump       = r_ex.jump;
    assign bubble_cnt       = r_bubble_cnt;
    assign flush_cnt        = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a reference model pushes expected ID/EX state
// and counters into a scoreboard queue, popped and compared after each edge.
module tb_id_ex_pipe_reg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        alu_src;
        logic        mrd;
        logic        mwr;
        logic        m2r;
        logic        rwe;
        logic        br;
        logic        jmp;
    } ex_t;

    typedef struct packed {
        ex_t              st;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] fc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n, stall_in, flush;
    logic u1, u2;
    ex_t  in_s;
    ex_t  obs;
    ex_t  m;
    logic [CNT_W-1:0] mb, mf;
    sb_t  sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic             o_valid, o_alu_src, o_mrd, o_mwr, o_m2r, o_rwe, o_br, o_jmp, o_stall;
    logic [XLEN-1:0]  o_pc, o_d1, o_d2, o_imm;
    logic [4:0]       o_rs1, o_rs2, o_rd;
    logic [3:0]       o_op;
    logic [CNT_W-1:0] o_bc, o_fc;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
        .id_valid(in_s.valid), .id_pc(in_s.pc), .id_rs1(in_s.rs1), .id_rs2(in_s.rs2),
        .id_rd(in_s.rd), .id_rs1_used(u1), .id_rs2_used(u2),
        .id_rs1_data(in_s.d1), .id_rs2_data(in_s.d2), .id_imm(in_s.imm),
        .id_alu_op(in_s.op), .id_alu_src(in_s.alu_src), .id_mem_rd_en(in_s.mrd),
        .id_mem_wr_en(in_s.mwr), .id_mem_to_reg(in_s.m2r), .id_reg_wr_en(in_s.rwe),
        .id_branch(in_s.br), .id_jump(in_s.jmp),
        .ID_EX_valid(o_valid), .ID_EX_pc(o_pc), .ID_EX_rs1(o_rs1), .ID_EX_rs2(o_rs2),
        .ID_EX_rd(o_rd), .ID_EX_rs1_data(o_d1), .ID_EX_rs2_data(o_d2), .ID_EX_imm(o_imm),
        .ID_EX_alu_op(o_op), .ID_EX_alu_src(o_alu_src), .ID_EX_mem_rd_en(o_mrd),
        .ID_EX_mem_wr_en(o_mwr), .ID_EX_mem_to_reg(o_m2r), .ID_EX_reg_wr_en(o_rwe),
        .ID_EX_branch(o_br), .ID_EX_jump(o_jmp),
        .load_use_stall(o_stall), .bubble_cnt(o_bc), .flush_cnt(o_fc)
    );

    assign obs = {o_valid, o_pc, o_rs1, o_rs2, o_rd, o_d1, o_d2, o_imm, o_op,
                  o_alu_src, o_mrd, o_mwr, o_m2r, o_rwe, o_br, o_jmp};

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic ex_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mrd, input logic rwe);
        ex_t e;
        e.valid = 1'b1; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.d1 = pc ^ 32'hA5A5_0F0F; e.d2 = ~pc; e.imm = pc + 32'd7; e.op = pc[5:2];
        e.alu_src = pc[2]; e.mrd = mrd; e.mwr = 1'b0; e.m2r = mrd; e.rwe = rwe;
        e.br = pc[3]; e.jmp = pc[4];
        return e;
    endfunction

    // One clock: drive controls, check the combinational stall, predict, then compare post-edge.
    task automatic step(input string tag, input logic rn, input logic fl, input logic st);
        logic hz;
        ex_t  nx;
        sb_t  exp_e;
        sb_t  got_e;
        rst_n = rn; flush = fl; stall_in = st;
        #2;
        hz = m.valid & m.mrd & m.rwe & (m.rd != 5'd0)
             & ((u1 & (in_s.rs1 == m.rd)) | (u2 & (in_s.rs2 == m.rd))) & in_s.valid;
        check({tag, ".stall"}, 160'(o_stall), 160'(hz & ~fl));
        nx = m;
        if (!rn) begin
            nx = '0; mb = '0; mf = '0;
        end else if (fl) begin
            nx = '0; if (mf != CNT_MAX) mf = mf + 1'b1;
        end else if (st) begin
            nx = m;
        end else if (hz) begin
            nx = '0; if (mb != CNT_MAX) mb = mb + 1'b1;
        end else if (!in_s.valid) begin
            nx = '0;
        end else begin
            nx = in_s;
        end
        exp_e.st = nx; exp_e.bc = mb; exp_e.fc = mf;
        sbq.push_back(exp_e);
        @(posedge clk);
        #1;
        got_e = sbq.pop_front();
        check({tag, ".idex"}, 160'(obs), 160'(got_e.st));
        check({tag, ".bubble_cnt"}, 160'(o_bc), 160'(got_e.bc));
        check({tag, ".flush_cnt"}, 160'(o_fc), 160'(got_e.fc));
        m = got_e.st;
        $display("step %s: rst_n=%0b flush=%0b stall_in=%0b pc=%0h rd=%0d stall=%0b bc=%0d fc=%0d",
                 tag, rn, fl, st, o_pc, o_rd, o_stall, o_bc, o_fc);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0;
        u1 = 1'b1; u2 = 1'b0;
        in_s = mk(32'h100, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        m = '0; mb = '0; mf = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a live instruction in ID, then released.
        step("rst0", 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0, 1'b0);
        step("rst_rel", 1'b1, 1'b0, 1'b0);
        check("rst_rel.rd5", 160'(o_rd), 160'(5));

        // lw x5 then add x6,x5,x1: one bubble, then the add is captured.
        in_s = mk(32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
        step("lw", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h108, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1); u1 = 1'b1; u2 = 1'b1;
        step("lu_bubble", 1'b1, 1'b0, 1'b0);
        step("lu_add", 1'b1, 1'b0, 1'b0);
        check("lu_add.rs1", 160'(o_rs1), 160'(5));

        // Loads to x0 and unused source fields never stall.
        in_s = mk(32'h10C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
        step("lw_x0", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h110, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1); u1 = 1'b1; u2 = 1'b1;
        step("use_x0", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h114, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
        step("lw_x5b", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h118, 5'd5, 5'd2, 5'd8, 1'b0, 1'b1); u1 = 1'b0; u2 = 1'b1;
        step("unused_rs1", 1'b1, 1'b0, 1'b0);

        // Flush beats stall_in and an active hazard.
        in_s = mk(32'h11C, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
        step("lw_x5c", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h120, 5'd3, 5'd5, 5'd9, 1'b0, 1'b1); u1 = 1'b1; u2 = 1'b1;
        step("flush_pri", 1'b1, 1'b1, 1'b1);

        // stall_in holds ID/EX for three cycles while ID changes.
        in_s = mk(32'h200, 5'd4, 5'd6, 5'd10, 1'b0, 1'b1); u1 = 1'b1; u2 = 1'b1;
        step("cap200", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_s = mk(32'h300 + 32'(i * 4), 5'd11, 5'd12, 5'd13, 1'b0, 1'b1);
            step("hold", 1'b1, 1'b0, 1'b1);
            check("hold.pc200", 160'(o_pc), 160'(32'h200));
        end
        step("hold_rel", 1'b1, 1'b0, 1'b0);

        // Empty ID slot captures as a full bubble.
        in_s = mk(32'h400, 5'd14, 5'd15, 5'd16, 1'b1, 1'b1); in_s.valid = 1'b0;
        step("id_invalid", 1'b1, 1'b0, 1'b0);

        // Reset arriving during a hazard wins, then normal capture resumes.
        in_s = mk(32'h404, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
        step("lw_x5d", 1'b1, 1'b0, 1'b0);
        in_s = mk(32'h408, 5'd5, 5'd0, 5'd17, 1'b0, 1'b1);
        step("rst_mid_hz", 1'b0, 1'b0, 1'b0);
        step("post_rst", 1'b1, 1'b0, 1'b0);

        // Twenty load-use bubbles saturate the 4-bit bubble counter at 15.
        for (int i = 0; i < 20; i++) begin
            in_s = mk(32'h500 + 32'(i * 8), 5'd1, 5'd0, 5'd5, 1'b1, 1'b1); u1 = 1'b1; u2 = 1'b0;
            step("sat_lw", 1'b1, 1'b0, 1'b0);
            in_s = mk(32'h504 + 32'(i * 8), 5'd5, 5'd0, 5'd18, 1'b0, 1'b1);
            step("sat_bubble", 1'b1, 1'b0, 1'b0);
        end
        check("bubble_cnt.sat15", 160'(o_bc), 160'(15));

        // Seventeen flushes saturate the flush counter as well.
        for (int i = 0; i < 17; i++) step("sat_flush", 1'b1, 1'b1, 1'b0);
        check("flush_cnt.sat15", 160'(o_fc), 160'(15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
